// File: rtl/cpu_pkg.sv
// Shared definitions for the 8080 pipeline: widths, reset PC, opcode
// encodings used by the length decoder and fetch-state enumeration.
package cpu_pkg;

    localparam int          ADDR_W   = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;

    // Single-opcode encodings the sequencer cares about
    localparam logic [7:0] OP_HLT  = 8'h76;
    localparam logic [7:0] OP_JMP  = 8'hC3;
    localparam logic [7:0] OP_CALL = 8'hCD;
    localparam logic [7:0] OP_SHLD = 8'h22;
    localparam logic [7:0] OP_LHLD = 8'h2A;
    localparam logic [7:0] OP_STA  = 8'h32;
    localparam logic [7:0] OP_LDA  = 8'h3A;
    localparam logic [7:0] OP_OUT  = 8'hD3;
    localparam logic [7:0] OP_IN   = 8'hDB;

    // Opcode families matched by (op & MASK) == MATCH
    localparam logic [7:0] OP_LXI_MASK   = 8'hCF;  // 00rp0001
    localparam logic [7:0] OP_LXI_MATCH  = 8'h01;
    localparam logic [7:0] OP_MVI_MASK   = 8'hC7;  // 00rrr110
    localparam logic [7:0] OP_MVI_MATCH  = 8'h06;
    localparam logic [7:0] OP_ALUI_MASK  = 8'hC7;  // 11xxx110
    localparam logic [7:0] OP_ALUI_MATCH = 8'hC6;
    localparam logic [7:0] OP_JCC_MASK   = 8'hC7;  // 11ccc010
    localparam logic [7:0] OP_JCC_MATCH  = 8'hC2;
    localparam logic [7:0] OP_CCC_MASK   = 8'hC7;  // 11ccc100
    localparam logic [7:0] OP_CCC_MATCH  = 8'hC4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/op_len.sv
// Opcode length decoder: maps an 8080 opcode to its byte length (1..3).
module op_len
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    // Three-byte forms first, then two-byte forms; everything else is one byte
    always_comb begin
        len = 2'd1;
        if (((opcode & OP_LXI_MASK) == OP_LXI_MATCH) ||
            (opcode == OP_SHLD) || (opcode == OP_LHLD) ||
            (opcode == OP_STA)  || (opcode == OP_LDA)  ||
            (opcode == OP_JMP)  || (opcode == OP_CALL) ||
            ((opcode & OP_JCC_MASK) == OP_JCC_MATCH) ||
            ((opcode & OP_CCC_MASK) == OP_CCC_MATCH)) begin
            len = 2'd3;
        end else if (((opcode & OP_MVI_MASK) == OP_MVI_MATCH) ||
                     ((opcode & OP_ALUI_MASK) == OP_ALUI_MATCH) ||
                     (opcode == OP_OUT) || (opcode == OP_IN)) begin
            len = 2'd2;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 8080 core: owns the PC, the two-cycle fetch
// FSM, the D-stage instruction latch and the per-stage valid bits.
module pipe_ctrl #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [23:0]       instruction,
    input  logic              stall_req,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              f1_v,
    output logic              f2_v,
    output logic              d_v,
    output logic              x1_v,
    output logic              x2_v,
    output logic              wb_v,
    output logic [23:0]       d_instr,
    output logic [1:0]        d_len,
    output logic              halted
);

    import cpu_pkg::*;

    fetch_state_t state;
    logic [1:0]   fetch_len;
    logic         consume;
    logic         hlt_take;
    logic         deliver;

    op_len u_fetch_len (
        .opcode (instruction[23:16]),
        .len    (fetch_len)
    );

    op_len u_d_len (
        .opcode (d_instr[23:16]),
        .len    (d_len)
    );

    assign f1_v = (state == FETCH);
    assign f2_v = (state == WAIT);

    // D drains when not stalled; a draining HLT blocks the concurrent refill
    always_comb begin
        consume  = d_v && !stall_req;
        hlt_take = consume && (d_instr[23:16] == OP_HLT);
        deliver  = (state == WAIT) && !stall_req && !hlt_take;
    end

    // Fetch FSM, PC, D latch, downstream valid shift and halt detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            d_v     <= 1'b0;
            x1_v    <= 1'b0;
            x2_v    <= 1'b0;
            wb_v    <= 1'b0;
            d_instr <= 24'h000000;
            halted  <= 1'b0;
        end else if (redirect_valid) begin
            state   <= FETCH;
            pc      <= redirect_pc;
            d_v     <= 1'b0;
            x1_v    <= 1'b0;
            x2_v    <= 1'b0;
            wb_v    <= x2_v;
            halted  <= 1'b0;
        end else begin
            wb_v   <= x2_v;
            x2_v   <= x1_v;
            x1_v   <= consume;
            halted <= (state == HALT) && !x1_v && !x2_v;
            if (deliver) begin
                d_instr <= instruction;
                d_v     <= 1'b1;
                pc      <= pc + {{(ADDR_W-2){1'b0}}, fetch_len};
            end else if (consume) begin
                d_v <= 1'b0;
            end
            case (state)
                FETCH:   state <= hlt_take ? HALT : WAIT;
                WAIT: begin
                    if (hlt_take) begin
                        state <= HALT;
                    end else if (!stall_req) begin
                        state <= FETCH;
                    end
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

endmodule
